// File: rtl/keypad_pkg.sv
// Shared constants, FSM state encoding and key-count classification for the keypad scanner.
package keypad_pkg;
  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_KEYS = 16;

  typedef enum logic {DRIVE, EVAL} kp_state_e;
  typedef enum logic [1:0] {NONE, ONE, MULTI} kp_class_e;

  function automatic kp_class_e kp_popcnt_class(input logic [KP_KEYS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < KP_KEYS; i++) n += int'(v[i]);
    if (n == 0) return NONE;
    if (n == 1) return ONE;
    return MULTI;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all ones so idle pulled-up inputs read as released.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, frame capture, debounce and single-key acceptance.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 8,
  parameter int DEBOUNCE = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KP_ROWS-1:0]  row,
  output logic [KP_COLS-1:0]  col,
  output logic [KP_KEYS-1:0]  key_onehot,
  output logic                key_valid,
  output logic                key_held,
  output logic                multi_key
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DB_MAX     = SW'(DEBOUNCE);

  logic [KP_ROWS-1:0] row_s;
  kp_state_e          state;
  logic [DW-1:0]      dwell;
  logic [1:0]         cidx;
  logic [KP_KEYS-1:0] frame;
  logic [KP_KEYS-1:0] prev;
  logic [SW-1:0]      stable_cnt;

  logic               same;
  logic [SW-1:0]      cnt_next;
  logic               accept;
  kp_class_e          cls;

  sync_2ff #(.WIDTH(KP_ROWS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_s)
  );

  // In EVAL cidx is still 3, so column 3 stays driven for the extra cycle.
  assign col = ~(4'b0001 << cidx);

  // Acceptance fires only on the step into saturation, or on any new frame when DEBOUNCE is 1.
  always_comb begin
    same     = (frame == prev);
    cnt_next = SW'(1);
    if (same) cnt_next = (stable_cnt == DB_MAX) ? stable_cnt : stable_cnt + 1'b1;
    accept   = (cnt_next == DB_MAX) && !(same && (stable_cnt == DB_MAX));
    cls      = kp_popcnt_class(frame);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DRIVE;
      dwell      <= '0;
      cidx       <= '0;
      frame      <= '0;
      prev       <= '0;
      stable_cnt <= '0;
      key_onehot <= '0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      multi_key  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        DRIVE: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            for (int r = 0; r < KP_ROWS; r++)
              frame[r*KP_COLS + int'(cidx)] <= ~row_s[r];
            if (cidx == 2'd3) state <= EVAL;
            else              cidx  <= cidx + 2'd1;
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        EVAL: begin
          state      <= DRIVE;
          cidx       <= '0;
          stable_cnt <= cnt_next;
          if (!same) prev <= frame;
          if (accept) begin
            case (cls)
              ONE: begin
                key_onehot <= frame;
                key_held   <= 1'b1;
                multi_key  <= 1'b0;
                key_valid  <= (frame != key_onehot);
              end
              MULTI: begin
                key_onehot <= '0;
                key_held   <= 1'b0;
                multi_key  <= 1'b1;
              end
              default: begin
                key_onehot <= '0;
                key_held   <= 1'b0;
                multi_key  <= 1'b0;
              end
            endcase
          end
        end
        default: state <= DRIVE;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives rows from col and a pressed-key mask.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] key_onehot;
  logic        key_valid, key_held, multi_key;
  logic [15:0] pressed = '0;
  int          k = 0;
  int          total = 0;
  int          bad = 0;

  keypad_scanner dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_onehot(key_onehot), .key_valid(key_valid),
    .key_held(key_held), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  function automatic logic [3:0] enc(input logic [15:0] v);
    enc = 4'h0;
    for (int i = 0; i < 16; i++) if (v[i]) enc = 4'(i);
  endfunction

  // k counts rising edges since reset release; sampling is on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic do_reset(input logic [15:0] p);
    @(negedge clk);
    rst_n   = 1'b0;
    pressed = p;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    int p;
    @(negedge clk);
    rst_n = 1'b0;
    pressed = '0;
    #1;
    total++;
    if ({col, key_onehot, key_valid, key_held, multi_key} !== {4'b1110, 16'h0, 3'b000}) begin
      bad++;
      $display("FAIL reset_vals col=%b onehot=%h v=%b h=%b m=%b required col=1110 rest 0",
               col, key_onehot, key_valid, key_held, multi_key);
    end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      p = k % 33;
      exp_col = ~(4'b0001 << ((p < 32) ? p / 8 : 3));
      total++;
      if (col !== exp_col || key_onehot !== 16'h0 || key_valid !== 1'b0 ||
          key_held !== 1'b0 || multi_key !== 1'b0) begin
        bad++;
        $display("FAIL idle_scan k=%0d col=%b onehot=%h v=%b h=%b m=%b required col=%b rest 0",
                 k, col, key_onehot, key_valid, key_held, multi_key, exp_col);
      end
      step();
    end
  endtask

  task automatic test_key5();
    int np = 0;
    int first = -1;
    do_reset(16'h0020);
    for (int i = 0; i < 260; i++) begin
      step();
      if (key_valid) begin np++; if (first < 0) first = k; end
      if (k == 98) begin
        total++;
        if (key_onehot !== 16'h0) begin bad++; $display("FAIL k5_early onehot=%h required 0000", key_onehot); end
      end
      if (k == 99) begin
        total++;
        if (key_onehot !== 16'h0020) begin bad++; $display("FAIL k5_onehot onehot=%h required 0020", key_onehot); end
        total++;
        if (enc(key_onehot) !== 4'h5) begin bad++; $display("FAIL k5_enc code=%h required 5", enc(key_onehot)); end
        total++;
        if (key_held !== 1'b1) begin bad++; $display("FAIL k5_held held=%b required 1", key_held); end
      end
      if (k == 100) begin
        total++;
        if (key_valid !== 1'b0) begin bad++; $display("FAIL k5_width valid=%b required 0", key_valid); end
      end
      if (k == 140) pressed = '0;
      if (k == 230) begin
        total++;
        if (key_onehot !== 16'h0020 || key_held !== 1'b1) begin
          bad++; $display("FAIL k5_hold onehot=%h held=%b required 0020/1", key_onehot, key_held);
        end
      end
      if (k == 231) begin
        total++;
        if (key_onehot !== 16'h0 || key_held !== 1'b0) begin
          bad++; $display("FAIL k5_release onehot=%h held=%b required 0000/0", key_onehot, key_held);
        end
      end
    end
    total++;
    if (np !== 1 || first !== 99) begin
      bad++; $display("FAIL k5_pulses count=%0d first=%0d required 1 at 99", np, first);
    end
  endtask

  task automatic test_bounce();
    int np = 0;
    int first = -1;
    do_reset(16'h0020);
    for (int i = 0; i < 240; i++) begin
      step();
      if (k <= 120 && k % 20 == 0) pressed = (k % 40 == 0) ? 16'h0020 : 16'h0000;
      if (key_valid) begin np++; if (first < 0) first = k; end
      if (k == 230) begin
        total++;
        if (key_onehot !== 16'h0 || multi_key !== 1'b0) begin
          bad++; $display("FAIL bnc_quiet onehot=%h m=%b required 0000/0", key_onehot, multi_key);
        end
      end
      if (k == 231) begin
        total++;
        if (key_onehot !== 16'h0020) begin bad++; $display("FAIL bnc_accept onehot=%h required 0020", key_onehot); end
      end
    end
    total++;
    if (np !== 1 || first !== 231) begin
      bad++; $display("FAIL bnc_pulses count=%0d first=%0d required 1 at 231", np, first);
    end
  endtask

  task automatic test_multi();
    int np = 0;
    int first = -1;
    do_reset(16'h8001);
    for (int i = 0; i < 210; i++) begin
      step();
      if (key_valid) begin np++; if (first < 0) first = k; end
      if (k == 98) begin
        total++;
        if (multi_key !== 1'b0) begin bad++; $display("FAIL mk_early m=%b required 0", multi_key); end
      end
      if (k == 99) begin
        total++;
        if (multi_key !== 1'b1 || key_onehot !== 16'h0 || key_held !== 1'b0) begin
          bad++; $display("FAIL mk_set m=%b onehot=%h h=%b required 1/0000/0", multi_key, key_onehot, key_held);
        end
      end
      if (k == 100) pressed = 16'h0001;
      if (k == 197) begin
        total++;
        if (multi_key !== 1'b1) begin bad++; $display("FAIL mk_hold m=%b required 1", multi_key); end
      end
      if (k == 198) begin
        total++;
        if (multi_key !== 1'b0 || key_onehot !== 16'h0001 || key_valid !== 1'b1) begin
          bad++; $display("FAIL mk_single m=%b onehot=%h v=%b required 0/0001/1", multi_key, key_onehot, key_valid);
        end
      end
    end
    total++;
    if (np !== 1 || first !== 198) begin
      bad++; $display("FAIL mk_pulses count=%0d first=%0d required 1 at 198", np, first);
    end
  endtask

  task automatic test_back_to_back();
    int np = 0;
    int last = -1;
    do_reset(16'h0020);
    for (int i = 0; i < 210; i++) begin
      step();
      if (key_valid) begin np++; last = k; end
      if (k == 100) pressed = 16'h0040;
      if (k == 150) begin
        total++;
        if (key_onehot !== 16'h0020 || key_held !== 1'b1) begin
          bad++; $display("FAIL slide_mid onehot=%h h=%b required 0020/1", key_onehot, key_held);
        end
      end
      if (k == 198) begin
        total++;
        if (key_onehot !== 16'h0040 || key_held !== 1'b1) begin
          bad++; $display("FAIL slide_new onehot=%h h=%b required 0040/1", key_onehot, key_held);
        end
      end
    end
    total++;
    if (np !== 2 || last !== 198) begin
      bad++; $display("FAIL slide_pulses count=%0d last=%0d required 2, last at 198", np, last);
    end
  endtask

  task automatic test_reset_mid();
    int np = 0;
    int first = -1;
    do_reset(16'h0020);
    while (k < 131) step();
    total++;
    if (col !== 4'b0111 || key_onehot !== 16'h0020) begin
      bad++; $display("FAIL rm_pre col=%b onehot=%h required 0111/0020", col, key_onehot);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({col, key_onehot, key_valid, key_held, multi_key} !== {4'b1110, 16'h0, 3'b000}) begin
      bad++;
      $display("FAIL rm_clear col=%b onehot=%h v=%b h=%b m=%b required col=1110 rest 0",
               col, key_onehot, key_valid, key_held, multi_key);
    end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (key_valid) begin np++; if (first < 0) first = k; end
    end
    total++;
    if (np !== 1 || first !== 99 || key_onehot !== 16'h0020) begin
      bad++; $display("FAIL rm_reaccept count=%0d first=%0d onehot=%h required 1 at 99, 0020",
                      np, first, key_onehot);
    end
  endtask

  initial begin
    test_reset();
    test_key5();
    test_bounce();
    test_multi();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
